// File: rtl/misr_bist_ctrl.sv
// Sequencing controller for a MISR signature compactor: seeds the MISR, feeds a
// programmed number of source beats into it, then captures and grades the signature.
module misr_bist_ctrl #(
   parameter int MISR_LFSR_DW = 8,
   parameter int CNT_W        = 16
) (
   input  logic                    func_clk,
   input  logic                    func_rst_n,
   input  logic                    cfg_start,
   input  logic                    cfg_abort,
   input  logic [MISR_LFSR_DW-1:0] cfg_seed,
   input  logic [CNT_W-1:0]        cfg_len,
   input  logic [MISR_LFSR_DW-1:0] cfg_golden,
   input  logic                    src_vld,
   output logic                    src_rdy,
   output logic                    lfsr_load,
   output logic                    lfsr_start,
   output logic [MISR_LFSR_DW-1:0] lfsr_seed,
   input  logic [MISR_LFSR_DW-1:0] misr_out,
   output logic                    busy,
   output logic                    done,
   output logic                    pass,
   output logic                    fail,
   output logic [MISR_LFSR_DW-1:0] sig_out,
   output logic [2:0]              dbg_state
);

   // Source handshake: a beat is transferred in any cycle where src_vld and
   // src_rdy are both high; src_rdy is high only in RUN, and the MISR advances
   // (lfsr_start) in exactly the cycles a beat is transferred.

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_RUN   = 3'd2,
      S_CHECK = 3'd3,
      S_DONE  = 3'd4
   } state_e;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_e                  state_q;
   logic [MISR_LFSR_DW-1:0] seed_q;
   logic [MISR_LFSR_DW-1:0] golden_q;
   logic [MISR_LFSR_DW-1:0] sig_q;
   logic [CNT_W-1:0]        len_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [CNT_W-1:0]        cnt_d;
   logic                    lfsr_load_q;
   logic                    src_rdy_q;
   logic                    busy_q;
   logic                    done_q;
   logic                    pass_q;
   logic                    fail_q;
   logic                    beat;
   logic                    last_beat;
   logic                    sig_match;

   assign beat      = src_rdy_q & src_vld;
   assign cnt_d     = cnt_q + CNT_ONE;
   // cnt_q never exceeds len-1 inside a run, so cnt_q+1 == len marks the last beat.
   assign last_beat = (cnt_d == len_q);
   assign sig_match = (misr_out == golden_q);

   always_ff @(posedge func_clk) begin
      if (!func_rst_n) begin
         state_q     <= S_IDLE;
         seed_q      <= '0;
         golden_q    <= '0;
         len_q       <= '0;
         cnt_q       <= '0;
         sig_q       <= '0;
         lfsr_load_q <= 1'b0;
         src_rdy_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_q      <= 1'b0;
      end else if (cfg_abort) begin
         // sig_q deliberately survives an abort so the last result stays readable.
         state_q     <= S_IDLE;
         lfsr_load_q <= 1'b0;
         src_rdy_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (cfg_start) begin
                  seed_q      <= cfg_seed;
                  len_q       <= cfg_len;
                  golden_q    <= cfg_golden;
                  cnt_q       <= '0;
                  done_q      <= 1'b0;
                  pass_q      <= 1'b0;
                  fail_q      <= 1'b0;
                  lfsr_load_q <= 1'b1;
                  busy_q      <= 1'b1;
                  state_q     <= S_LOAD;
               end
            end
            S_LOAD: begin
               lfsr_load_q <= 1'b0;
               cnt_q       <= '0;
               if (len_q != '0) begin
                  src_rdy_q <= 1'b1;
                  state_q   <= S_RUN;
               end else begin
                  state_q   <= S_CHECK;
               end
            end
            S_RUN: begin
               if (beat) begin
                  cnt_q <= cnt_d;
                  if (last_beat) begin
                     src_rdy_q <= 1'b0;
                     state_q   <= S_CHECK;
                  end
               end
            end
            S_CHECK: begin
               sig_q   <= misr_out;
               pass_q  <= sig_match;
               fail_q  <= ~sig_match;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_DONE;
            end
            default: begin
               src_rdy_q   <= 1'b0;
               lfsr_load_q <= 1'b0;
               busy_q      <= 1'b0;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

   assign src_rdy    = src_rdy_q;
   assign lfsr_load  = lfsr_load_q;
   assign lfsr_start = beat;
   assign lfsr_seed  = seed_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign fail       = fail_q;
   assign sig_out    = sig_q;
   assign dbg_state  = state_q;

endmodule

// File: doc/misr_bist_ctrl.md
# misr_bist_ctrl

Sequencing controller for the `generic_misr` signature compactor in logic-BIST and memory-BIST wrappers. It loads a seed, drives a programmed number of compaction beats from a valid/ready data source, and captures the final signature. It then compares the signature against a golden value and reports pass/fail. One instance sits beside each MISR and is configured by the local test register block.

## Interface
Parameters:
- MISR_LFSR_DW, 8, MISR width; must match the attached MISR (2..32)
- CNT_W, 16, width of the beat-length counter

Ports:
- func_clk  in  1  functional clock; all logic on posedge
- func_rst_n  in  1  reset, synchronous, active-low
- cfg_start  in  1  one-cycle start pulse; honoured only in IDLE or DONE
- cfg_abort  in  1  abort; returns to IDLE from any state; has priority over cfg_start
- cfg_seed  in  MISR_LFSR_DW  seed loaded into the MISR
- cfg_len  in  CNT_W  number of compaction beats (0 allowed)
- cfg_golden  in  MISR_LFSR_DW  expected signature
- src_vld  in  1  source beat valid
- src_rdy  out  1  controller accepts beats (RUN state)
- lfsr_load  out  1  to MISR lfsr_load
- lfsr_start  out  1  to MISR lfsr_start
- lfsr_seed  out  MISR_LFSR_DW  to MISR lfsr_seed (= cfg_seed captured at start)
- misr_out  in  MISR_LFSR_DW  MISR register value
- busy  out  1  state is LOAD, RUN or CHECK
- done  out  1  level, high in DONE
- pass  out  1  valid while done; signature == golden
- fail  out  1  valid while done; signature != golden
- sig_out  out  MISR_LFSR_DW  captured final signature

## Operation
- States: IDLE, LOAD, RUN, CHECK, DONE (registered state).
- Start handling:
  - cfg_start in IDLE/DONE: capture cfg_seed, cfg_len and cfg_golden into shadow registers; clear done/pass/fail; go to LOAD.
  - cfg_start while busy is ignored.
  - Config inputs may change after the start cycle without effect.
- LOAD: lfsr_load=1 for exactly one cycle; beat counter cleared. Next state is RUN if len!=0, otherwise CHECK.
- RUN:
  - src_rdy=1; lfsr_start = src_vld (combinational, same cycle). A beat is a cycle with src_vld=1.
  - Counter increments per beat. The beat with counter == len-1 moves the state to CHECK.
  - src_vld gaps stall the controller with the MISR held (lfsr_start=0).
- CHECK: misr_out now holds the final signature. Register sig_out=misr_out, pass=(misr_out==golden), fail=!pass; go to DONE.
- DONE: done=1; sig_out/pass/fail held until the next start, abort or reset.
- Abort, any state: next state IDLE. done/pass/fail cleared; sig_out keeps its last value; MISR contents undefined to the caller.
- lfsr_load and lfsr_start are never high together. src_rdy and lfsr_start are 0 outside RUN.
- Counter width CNT_W; len up to 2^CNT_W-1; no wrap inside a run.

## Timing
- Reset values: state IDLE, lfsr_load=0, lfsr_start=0, src_rdy=0, busy=0, done=0, pass=0, fail=0, sig_out=0, lfsr_seed=0, counter=0.
- Start pulse at cycle t:
  - LOAD at t+1.
  - RUN from t+2.
  - With continuous src_vld, the last beat is at t+len+1, CHECK at t+len+2, done=1 from t+len+3.
- len=0: LOAD t+1, CHECK t+2, done t+3; signature = seed.
- Each src_vld gap adds one cycle.
- Reset mid-run: next cycle all outputs at reset values.
- Simultaneous cfg_abort and cfg_start: abort wins; result is IDLE and no run starts.

## Test plan
- Seed 8'h01, len 4, misr_in 0, src_vld constant -> sig_out 8'h10, done at start+7. With golden 8'h10: pass=1, fail=0.
- Seed 8'h00, len 4, misr_in 8'h01 each beat -> sig_out 8'h0F. With golden 8'h0E: fail=1, pass=0.
- Same as the first scenario with src_vld toggling 1,0,1,0,... -> same signature 8'h10. lfsr_start exactly 4 cycles high; done delayed by 3 cycles.
- len 0, seed 8'hA5, golden 8'hA5 -> done at start+3, pass=1. lfsr_start never asserted.
- Abort in RUN after 2 beats -> IDLE next cycle, busy=0, done=0. A new start then completes the first scenario correctly.
- cfg_start pulsed during RUN -> ignored; beat count and signature unchanged. func_rst_n low during RUN -> all outputs at reset values next cycle.
